// File: rtl/fibonacci_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fibonacci_pkg
//  Description : Shared constants, FSM state type and BCD helper for the
//                inverse Fibonacci core.
//                Contents: N_MAX, BCD_DIGITS, BIN_W, T_W, N_W,
//                BCD2BIN_CYCLES, BIN2BCD_CYCLES, state_e, bcd_has_invalid().
//  Revision    : 1.0 - initial release
// ============================================================================
package fibonacci_pkg;

    localparam int N_MAX          = 21;  // F(21) = 10946 covers 9999
    localparam int BCD_DIGITS     = 4;
    localparam int BIN_W          = 16;
    localparam int T_W            = 15;
    localparam int N_W            = 5;
    localparam int BCD2BIN_CYCLES = 16;
    localparam int BIN2BCD_CYCLES = 5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BCD2BIN = 3'd1,
        S_FIBO    = 3'd2,
        S_BIN2BCD = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    // True when any nibble of the packed BCD word is outside 0..9.
    function automatic logic bcd_has_invalid(input logic [4*BCD_DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd2bin_serial.sv
`default_nettype none
// ============================================================================
//  Module      : bcd2bin_serial
//  Description : Serial 4-digit BCD to 16-bit binary converter using the
//                shift-right / subtract-3 algorithm, one bit per cycle.
//  Ports       : clk, rst_n   - clock, async active-low reset
//                load_i       - capture bcd_i and start a conversion
//                bcd_i[15:0]  - packed BCD, [15:12] = thousands
//                done_o       - high during the final shift cycle; bin_o is
//                               valid from the following cycle
//                bin_o[15:0]  - binary result (holds until next load)
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd2bin_serial
    import fibonacci_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [BIN_W-1:0] bcd_i,
    output logic             done_o,
    output logic [BIN_W-1:0] bin_o
);

    localparam int CNT_W = $clog2(BCD2BIN_CYCLES + 1);

    logic [BIN_W-1:0] digits_q;
    logic [BIN_W-1:0] digits_d;
    logic [BIN_W-1:0] bin_q;
    logic [BIN_W-1:0] bin_d;
    logic [CNT_W-1:0] cnt_q;

    // One step: shift {digits, bin} right, then pull any digit that now
    // reads 8 or more back down by 3 (undoing the x2 carry into it).
    always_comb begin
        {digits_d, bin_d} = {1'b0, digits_q, bin_q[BIN_W-1:1]};
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (digits_d[4*i +: 4] > 4'd7) begin
                digits_d[4*i +: 4] = digits_d[4*i +: 4] - 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
            bin_q    <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            digits_q <= bcd_i;
            bin_q    <= '0;
            cnt_q    <= CNT_W'(BCD2BIN_CYCLES);
        end else if (cnt_q != '0) begin
            digits_q <= digits_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_q - CNT_W'(1);
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));
    assign bin_o  = bin_q;

endmodule
`default_nettype wire

// File: rtl/fibonacci_inverse.sv
`default_nettype none
// ============================================================================
//  Module      : fibonacci_inverse
//  Description : Inverse Fibonacci core. Finds the smallest n with
//                F(n) >= value for a 4-digit BCD value and reports n as two
//                BCD digits plus an exact-match flag.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                start           - request pulse, sampled in IDLE only
//                bcd_in[15:0]    - BCD value, captured on accepted start
//                busy            - high from cycle after start through DONE
//                done            - one-cycle result strobe
//                idx_bcd[7:0]    - n in BCD, [7:4] = tens
//                exact           - F(n) == value
//                err             - input held a nibble > 9
//  Revision    : 1.0 - initial release
// ============================================================================
module fibonacci_inverse
    import fibonacci_pkg::*;
#(
    parameter int BCD_DIGITS = 4,
    parameter int N_MAX      = 21
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [4*BCD_DIGITS-1:0] bcd_in,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              idx_bcd,
    output logic                    exact,
    output logic                    err
);

    localparam int DAB_W = 8 + N_W;

    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic [7:0]       idx_bcd_q;
    logic             exact_q;
    logic             err_q;
    logic             exact_res_q;
    logic [T_W-1:0]   t0_q;
    logic [T_W-1:0]   t1_q;
    logic [N_W-1:0]   n_q;
    logic [DAB_W-1:0] dab_q;
    logic [DAB_W-1:0] dab_d;
    logic [DAB_W-1:0] dab_adj;
    logic [2:0]       dab_cnt_q;

    logic             conv_load;
    logic             conv_done;
    logic [BIN_W-1:0] conv_bin;
    logic             in_invalid;

    assign in_invalid = bcd_has_invalid(bcd_in);
    assign conv_load  = (state_q == S_IDLE) && start && !in_invalid;

    bcd2bin_serial u_bcd2bin (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (conv_load),
        .bcd_i  (bcd_in),
        .done_o (conv_done),
        .bin_o  (conv_bin)
    );

    // Double-dabble step on {tens, ones, n}: add 3 to digits >= 5, shift left.
    always_comb begin
        dab_adj = dab_q;
        if (dab_adj[DAB_W-1 -: 4] >= 4'd5) begin
            dab_adj[DAB_W-1 -: 4] = dab_adj[DAB_W-1 -: 4] + 4'd3;
        end
        if (dab_adj[DAB_W-5 -: 4] >= 4'd5) begin
            dab_adj[DAB_W-5 -: 4] = dab_adj[DAB_W-5 -: 4] + 4'd3;
        end
        dab_d = {dab_adj[DAB_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            idx_bcd_q   <= 8'h00;
            exact_q     <= 1'b0;
            err_q       <= 1'b0;
            exact_res_q <= 1'b0;
            t0_q        <= '0;
            t1_q        <= '0;
            n_q         <= '0;
            dab_q       <= '0;
            dab_cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (in_invalid) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            err_q     <= 1'b1;
                            exact_q   <= 1'b0;
                            idx_bcd_q <= 8'h00;
                        end else begin
                            state_q <= S_BCD2BIN;
                        end
                    end
                end

                S_BCD2BIN: begin
                    // conv_done marks the last shift; bin is valid on FIBO entry.
                    if (conv_done) begin
                        state_q <= S_FIBO;
                        t0_q    <= '0;
                        t1_q    <= T_W'(1);
                        n_q     <= N_W'(1);
                    end
                end

                S_FIBO: begin
                    if (conv_bin == '0) begin
                        state_q     <= S_BIN2BCD;
                        dab_q       <= '0;
                        exact_res_q <= 1'b1;
                        dab_cnt_q   <= 3'(BIN2BCD_CYCLES);
                    end else if (({1'b0, t1_q} >= conv_bin) || (n_q == N_W'(N_MAX))) begin
                        state_q     <= S_BIN2BCD;
                        dab_q       <= {8'h00, n_q};
                        exact_res_q <= ({1'b0, t1_q} == conv_bin);
                        dab_cnt_q   <= 3'(BIN2BCD_CYCLES);
                    end else begin
                        t1_q <= t0_q + t1_q;
                        t0_q <= t1_q;
                        n_q  <= n_q + N_W'(1);
                    end
                end

                S_BIN2BCD: begin
                    dab_q     <= dab_d;
                    dab_cnt_q <= dab_cnt_q - 3'd1;
                    // Final shift lands directly in the output register.
                    if (dab_cnt_q == 3'd1) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        idx_bcd_q <= dab_d[DAB_W-1 -: 8];
                        exact_q   <= exact_res_q;
                        err_q     <= 1'b0;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign idx_bcd = idx_bcd_q;
    assign exact   = exact_q;
    assign err     = err_q;

endmodule
`default_nettype wire
